branch_resolution_unit: RTL and testbench

//  EX-stage counterpart of the 2-bit branch predictor. Queues each fetch-time prediction
//  (direction, target, fall-through PC) in program order. Checks it against the branch

---
 rtl/bru_pkg.sv | 18 +
 rtl/branch_resolution_unit_pred_queue.sv | 68 ++++++
 rtl/branch_resolution_unit.sv | 129 ++++++++++++
 tb/tb_branch_resolution_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolution unit and its prediction queue.
package bru_pkg;

    localparam int          BRU_XLEN = 32;
    localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

    // One fetch-time prediction, stored in program order until EX resolves it.
    typedef struct packed {
        logic                taken;
        logic [BRU_XLEN-1:0] target;
        logic [BRU_XLEN-1:0] fallthru;
    } pred_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/branch_resolution_unit_pred_queue.sv
// In-order FIFO of outstanding predictions; clear beats push, full+push+pop keeps occupancy.
module pred_queue
    import bru_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  pred_entry_t entry_i,
    input  logic        pop_i,
    input  logic        clear_i,
    output pred_entry_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] count;
    logic          push_ok;
    logic          pop_ok;
    pred_entry_t   mem_q [DEPTH];

    assign count   = wr_q - rd_q;
    assign full_o  = (count == PW'(DEPTH));
    assign empty_o = (count == '0);
    assign pop_ok  = pop_i & ~empty_o;
    // A full queue can still accept a push when the head leaves in the same cycle.
    assign push_ok = push_i & ~clear_i & (~full_o | pop_ok);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clear_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + PW'(1);
            if (pop_ok)  rd_d = rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (push_ok && (wr_q[AW-1:0] == AW'(gi))) begin
                    mem_q[gi] <= entry_i;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/branch_resolution_unit.sv
// EX-stage branch checker: compares resolved outcomes against queued predictions and
// produces predictor training pulses, flush/redirect on mispredict, and statistics.
module branch_resolution_unit
    import bru_pkg::*;
#(
    parameter int XLEN  = BRU_XLEN,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            pred_valid,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    input  logic [XLEN-1:0] pred_fallthru,
    output logic            pq_full,
    input  logic            ex_valid,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    output logic            taken,
    output logic            not_taken,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt,
    output logic            pq_err
);

    pred_entry_t     push_entry;
    pred_entry_t     head;
    logic            q_empty;
    logic            q_full;
    logic            push_req;
    logic            resolve;
    logic            head_taken;
    logic [XLEN-1:0] head_target;
    logic [XLEN-1:0] head_fallthru;
    logic            mispred;
    logic            overflow;
    logic            underflow;

    logic            taken_q, taken_d;
    logic            not_taken_q, not_taken_d;
    logic            flush_q, flush_d;
    logic [XLEN-1:0] redirect_q, redirect_d;
    logic [31:0]     branch_cnt_q, branch_cnt_d;
    logic [31:0]     mispred_cnt_q, mispred_cnt_d;
    logic            err_q, err_d;

    assign push_req   = pred_valid & ~stall;
    assign resolve    = ex_valid & ~stall;
    assign push_entry = '{taken: pred_taken, target: pred_target, fallthru: pred_fallthru};

    pred_queue #(
        .DEPTH (DEPTH)
    ) u_pred_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .entry_i (push_entry),
        .pop_i   (resolve),
        .clear_i (mispred),
        .head_o  (head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // Resolving with nothing queued behaves like a not-taken guess falling through to ex_target.
    assign head_taken    = q_empty ? 1'b0      : head.taken;
    assign head_target   = q_empty ? ex_target : head.target;
    assign head_fallthru = q_empty ? ex_target : head.fallthru;

    assign mispred = resolve &
                     ((ex_taken != head_taken) |
                      (ex_taken & head_taken & (ex_target != head_target)));

    // A push blocked by a full queue is an error only if no head leaves this cycle.
    assign overflow  = push_req & q_full & ~resolve;
    assign underflow = resolve & q_empty;

    always_comb begin
        taken_d       = resolve & ex_taken;
        not_taken_d   = resolve & ~ex_taken;
        flush_d       = mispred;
        redirect_d    = redirect_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        err_d         = err_q | overflow | underflow;
        if (mispred) begin
            redirect_d = ex_taken ? ex_target : head_fallthru;
        end
        if (resolve) begin
            branch_cnt_d = sat_inc(branch_cnt_q);
        end
        if (mispred) begin
            mispred_cnt_d = sat_inc(mispred_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_q       <= 1'b0;
            not_taken_q   <= 1'b0;
            flush_q       <= 1'b0;
            redirect_q    <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            err_q         <= 1'b0;
        end else begin
            taken_q       <= taken_d;
            not_taken_q   <= not_taken_d;
            flush_q       <= flush_d;
            redirect_q    <= redirect_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            err_q         <= err_d;
        end
    end

    assign pq_full     = q_full;
    assign taken       = taken_q;
    assign not_taken   = not_taken_q;
    assign flush       = flush_q;
    assign redirect_pc = redirect_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
    assign pq_err      = err_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench: directed scenarios then random traffic against a queue-based model.
module tb_branch_resolution_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] pred_fallthru;
    logic        pq_full;
    logic        ex_valid;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        taken;
    logic        not_taken;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;
    logic        pq_err;

    always #5 clk = ~clk;

    branch_resolution_unit #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .pred_fallthru (pred_fallthru),
        .pq_full       (pq_full),
        .ex_valid      (ex_valid),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .taken         (taken),
        .not_taken     (not_taken),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt),
        .pq_err        (pq_err)
    );

    typedef struct {
        bit        t;
        bit [31:0] tg;
        bit [31:0] ft;
    } m_entry_t;

    m_entry_t  mq[$];
    bit        m_taken, m_nt, m_flush, m_err;
    bit [31:0] m_redir, m_bc, m_mc;
    int        checks = 0;
    int        failures = 0;
    int        txn = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL txn=%0d %s got=%h exp=%h", txn, tag, got, exp);
        end
    endtask

    // Reference model: applies one cycle of the branch-resolution rules to the queue.
    task automatic model_step(input bit pv, input bit pt, input bit [31:0] ptg, input bit [31:0] pft,
                              input bit ev, input bit et, input bit [31:0] etg,
                              input bit st, input bit r);
        bit       res, mis, was_full;
        m_entry_t h;
        if (r) begin
            mq.delete();
            m_taken = 0; m_nt = 0; m_flush = 0; m_err = 0;
            m_redir = 0; m_bc = 0; m_mc = 0;
            return;
        end
        res      = ev && !st;
        was_full = (mq.size() == DEPTH);
        if (mq.size() == 0) begin
            h.t = 0; h.tg = etg; h.ft = etg;
            if (res) m_err = 1;
        end else begin
            h = mq[0];
        end
        mis     = res && ((et != h.t) || (et && h.t && etg != h.tg));
        m_taken = res && et;
        m_nt    = res && !et;
        m_flush = mis;
        if (mis) m_redir = et ? etg : h.ft;
        if (res && m_bc != 32'hFFFF_FFFF) m_bc++;
        if (mis && m_mc != 32'hFFFF_FFFF) m_mc++;
        if (res && mq.size() > 0) void'(mq.pop_front());
        if (mis) begin
            mq.delete();
        end else if (pv && !st) begin
            if (was_full && !res) m_err = 1;
            else mq.push_back('{t: pt, tg: ptg, ft: pft});
        end
    endtask

    task automatic step(input bit pv, input bit pt, input bit [31:0] ptg, input bit [31:0] pft,
                        input bit ev, input bit et, input bit [31:0] etg,
                        input bit st, input bit r);
        rst = r; stall = st;
        pred_valid = pv; pred_taken = pt; pred_target = ptg; pred_fallthru = pft;
        ex_valid = ev; ex_taken = et; ex_target = etg;
        model_step(pv, pt, ptg, pft, ev, et, etg, st, r);
        @(posedge clk);
        #1;
        txn++;
        check_eq("taken", {31'd0, taken}, {31'd0, m_taken});
        check_eq("not_taken", {31'd0, not_taken}, {31'd0, m_nt});
        check_eq("flush", {31'd0, flush}, {31'd0, m_flush});
        check_eq("redirect_pc", redirect_pc, m_redir);
        check_eq("branch_cnt", branch_cnt, m_bc);
        check_eq("mispred_cnt", mispred_cnt, m_mc);
        check_eq("pq_err", {31'd0, pq_err}, {31'd0, m_err});
        check_eq("pq_full", {31'd0, pq_full}, {31'd0, (mq.size() == DEPTH)});
        $display("txn=%0d rst=%0b st=%0b pv=%0b ev=%0b et=%0b -> tk=%0b nt=%0b fl=%0b pc=%h bc=%0d mc=%0d err=%0b full=%0b",
                 txn, r, st, pv, ev, et, taken, not_taken, flush, redirect_pc,
                 branch_cnt, mispred_cnt, pq_err, pq_full);
    endtask

    task automatic push(input bit pt, input bit [31:0] ptg, input bit [31:0] pft);
        step(1, pt, ptg, pft, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input bit et, input bit [31:0] etg);
        step(0, 0, 0, 0, 1, et, etg, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rst = 1; stall = 0; pred_valid = 0; pred_taken = 0; pred_target = 0;
        pred_fallthru = 0; ex_valid = 0; ex_taken = 0; ex_target = 0;
        do_reset();

        // 1: correct not-taken
        push(0, 32'h100, 32'h0C4);
        resolve(0, 32'h0);
        // 2: direction mispredict
        push(0, 32'h200, 32'h084);
        resolve(1, 32'h200);
        // 3: target mispredict, then taken-predicted resolved not taken
        push(1, 32'h300, 32'h010);
        resolve(1, 32'h340);
        push(1, 32'h3A0, 32'h014);
        resolve(0, 32'h0);
        // 4: fill, overflow, push+pop while full, drain in order
        for (int i = 0; i < DEPTH; i++) push(1, 32'h400 + 32'(16 * i), 32'h500 + 32'(i));
        push(1, 32'h4F0, 32'h5F0);
        step(1, 0, 32'h480, 32'h580, 1, 1, 32'h400, 0, 0);
        for (int i = 1; i < DEPTH; i++) resolve(1, 32'h400 + 32'(16 * i));
        resolve(0, 32'h0);
        // 5: mispredict with younger entries and a same-cycle push, then resolve on empty
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(1, 32'h600 + 32'(16 * i), 32'h700 + 32'(i));
        step(1, 1, 32'h6F0, 32'h7F0, 1, 0, 32'h0, 0, 0);
        resolve(1, 32'h800);
        // 6: stall during resolve, release, then reset mid-stream
        do_reset();
        push(0, 32'h900, 32'h904);
        step(1, 1, 32'h910, 32'h914, 1, 0, 32'h0, 1, 0);
        step(0, 0, 0, 0, 1, 0, 32'h0, 0, 0);
        push(1, 32'hA00, 32'hA04);
        push(1, 32'hA10, 32'hA14);
        step(1, 1, 32'hA20, 32'hA24, 1, 0, 32'h0, 0, 1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            bit        pv, pt, ev, et, st, r;
            bit [31:0] ptg, etg;
            pv  = ($urandom_range(0, 99) < 60);
            pt  = $urandom_range(0, 1);
            ptg = 32'h1000 + 32'(4 * $urandom_range(0, 3));
            ev  = ($urandom_range(0, 99) < (mq.size() == 0 ? 5 : 45));
            et  = (mq.size() > 0 && $urandom_range(0, 99) < 75) ? mq[0].t : 1'($urandom_range(0, 1));
            etg = (mq.size() > 0 && $urandom_range(0, 99) < 75) ? mq[0].tg
                                                                : 32'h1000 + 32'(4 * $urandom_range(0, 3));
            st  = ($urandom_range(0, 99) < 10);
            r   = ($urandom_range(0, 999) < 8);
            step(pv, pt, ptg, 32'h2000 + 32'($urandom_range(0, 255)), ev, et, etg, st, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
